// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared fetch/decode parameters and queue entry record.
package inst_fetch_queue_pkg;
    localparam int IFQ_DEPTH = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'd0;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush and occupancy count.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t data_o,
    output logic         valid_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic push_en, pop_en;
    assign pop_en  = pop_i && count_q != '0;
    assign push_en = push_i && count_q != CW'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_en);
            rd_q    <= rd_q + AW'(pop_en);
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end
    always_ff @(posedge clk) begin
        if (push_en && !flush_i && !rst) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign valid_o = count_q != '0;
    assign count_o = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC generation, single-outstanding IMEM fetch and redirect into a prefetch queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          RN,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          br_en,
    input  logic [31:0]   br_target,
    output logic          if_valid,
    output logic [31:0]   if_ir,
    output logic [31:0]   if_npc,
    input  logic          id_ready,
    output logic [CW-1:0] q_count
);
    logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic inflight_q, inflight_d;
    logic flush, push, pop, head_valid;
    logic [CW-1:0] count;
    fetch_entry_t head, push_data;
    always_comb begin
        flush      = RN || br_en;
        imem_req   = !flush && (int'(count) + int'(inflight_q) < DEPTH);
        push       = inflight_q && !flush;
        pop        = if_valid && id_ready && !flush;
        pc_d       = br_en ? br_target : pc_q + 32'(imem_req);
        inflight_d = imem_req;
        req_addr_d = imem_req ? pc_q : req_addr_q;
        push_data  = '{ir: imem_rdata, npc: req_addr_q + 32'd1};
        imem_addr  = RN ? RESET_PC : pc_q;
        if_valid   = head_valid && !RN;
        if_ir      = if_valid ? head.ir : '0;
        if_npc     = if_valid ? head.npc : '0;
        q_count    = RN ? '0 : count;
    end
    // A redirect or reset kills the outstanding request so its response is never queued.
    always_ff @(posedge clk) begin
        if (RN) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (RN),
        .flush_i (br_en),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (head_valid),
        .count_o (count)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table vectors, directed corner sequences and a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'd0;
    logic clk = 1'b0;
    logic rn, br, idr;
    logic [31:0] tgt;
    logic imem_req, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_ir, if_npc;
    logic [2:0] q_count;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;
    ent_t mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_iaddr = '0;
    logic m_infl = 1'b0;
    logic m_req = 1'b0;
    typedef struct {
        logic rn, br, idr;
        logic [31:0] tgt;
        logic req;
        logic [31:0] addr;
        logic vld;
        logic [31:0] ir, npc;
        int cnt;
    } vec_t;
    vec_t vt[7];

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .RN(rn), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .br_en(br), .br_target(tgt), .if_valid(if_valid),
        .if_ir(if_ir), .if_npc(if_npc), .id_ready(idr), .q_count(q_count)
    );

    always #5 clk = ~clk;
    // IMEM holds 32'h1000 + address; unrequested cycles return junk so stale pushes show up.
    always @(posedge clk) imem_rdata <= imem_req ? 32'h1000 + imem_addr : $urandom;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int occ = mq.size();
        logic e_vld = !rn && occ > 0;
        m_req = !rn && !br && (occ + int'(m_infl) < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req || rn) chk("imem_addr", imem_addr, rn ? RESET_PC : m_pc);
        chk("if_valid", 32'(if_valid), 32'(e_vld));
        chk("if_ir", if_ir, e_vld ? mq[0].ir : 32'h0);
        chk("if_npc", if_npc, e_vld ? mq[0].npc : 32'h0);
        chk("q_count", 32'(q_count), rn ? 32'd0 : 32'(occ));
    endtask

    task automatic model_update();
        if (rn) begin
            mq.delete();
            m_pc = RESET_PC;
            m_infl = 1'b0;
        end else if (br) begin
            mq.delete();
            m_pc = tgt;
            m_infl = 1'b0;
        end else begin
            if (mq.size() > 0 && idr) void'(mq.pop_front());
            if (m_infl) mq.push_back('{32'h1000 + m_iaddr, m_iaddr + 32'd1});
            m_infl = m_req;
            if (m_req) begin
                m_iaddr = m_pc;
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            eval_cycle();
            adv();
        end
    endtask

    initial begin
        rn = 1'b1; br = 1'b0; idr = 1'b1; tgt = '0;
        vt[0] = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0,    32'd0, 0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 32'h0,    32'd0, 0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd1, 1'b0, 32'h0,    32'd0, 0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd2, 1'b1, 32'h1000, 32'd1, 1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd3, 1'b1, 32'h1001, 32'd2, 1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd4, 1'b1, 32'h1002, 32'd3, 1};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd5, 1'b1, 32'h1003, 32'd4, 1};
        for (int i = 0; i < 7; i++) begin
            rn = vt[i].rn; br = vt[i].br; idr = vt[i].idr; tgt = vt[i].tgt;
            eval_cycle();
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].req));
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("vec%0d_vld", i), 32'(if_valid), 32'(vt[i].vld));
            chk($sformatf("vec%0d_ir", i), if_ir, vt[i].ir);
            chk($sformatf("vec%0d_npc", i), if_npc, vt[i].npc);
            chk($sformatf("vec%0d_cnt", i), 32'(q_count), 32'(vt[i].cnt));
            adv();
        end
        // Backpressure: queue fills to DEPTH, then a single pop frees one slot.
        rn = 1'b1; cyc(1);
        rn = 1'b0; idr = 1'b0; cyc(8);
        eval_cycle(); chk("sat_cnt", 32'(q_count), 32'd4); chk("sat_req", 32'(imem_req), 32'd0); adv();
        idr = 1'b1;
        eval_cycle(); chk("pulse_ir", if_ir, 32'h1000); adv();
        idr = 1'b0;
        eval_cycle(); chk("pop1_cnt", 32'(q_count), 32'd3); chk("pop1_req", 32'(imem_req), 32'd1);
        chk("pop1_addr", imem_addr, 32'd4); adv();
        eval_cycle(); chk("pop1_noreq", 32'(imem_req), 32'd0); chk("pop1_cnt2", 32'(q_count), 32'd3); adv();
        eval_cycle(); chk("refill_cnt", 32'(q_count), 32'd4); adv();
        // Redirect with three queued entries and one request in flight.
        idr = 1'b1; cyc(1);
        idr = 1'b0; cyc(1);
        br = 1'b1; tgt = 32'd25;
        eval_cycle(); chk("pre_br_cnt", 32'(q_count), 32'd3); adv();
        br = 1'b0;
        eval_cycle(); chk("br_cnt", 32'(q_count), 32'd0); chk("br_req", 32'(imem_req), 32'd1);
        chk("br_addr", imem_addr, 32'd25); chk("br_vld", 32'(if_valid), 32'd0); adv();
        eval_cycle(); chk("br_vld2", 32'(if_valid), 32'd0); adv();
        eval_cycle(); chk("br_ir", if_ir, 32'h1019); chk("br_npc", if_npc, 32'd26); adv();
        // Redirect coinciding with a pop and a returning response.
        idr = 1'b1; cyc(6);
        br = 1'b1; tgt = 32'd100;
        eval_cycle(); chk("bp_vld", 32'(if_valid), 32'd1); adv();
        br = 1'b0;
        eval_cycle(); chk("bp_cnt", 32'(q_count), 32'd0); chk("bp_vld0", 32'(if_valid), 32'd0);
        chk("bp_addr", imem_addr, 32'd100); adv();
        eval_cycle(); chk("bp_vld1", 32'(if_valid), 32'd0); adv();
        eval_cycle(); chk("bp_ir", if_ir, 32'h1064); chk("bp_npc", if_npc, 32'd101); adv();
        // Reset beats a simultaneous redirect.
        cyc(5);
        rn = 1'b1; br = 1'b1; tgt = 32'd77;
        eval_cycle(); chk("rst_req", 32'(imem_req), 32'd0); chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_vld", 32'(if_valid), 32'd0); chk("rst_ir", if_ir, 32'h0); chk("rst_cnt", 32'(q_count), 32'd0); adv();
        rn = 1'b0; br = 1'b0;
        eval_cycle(); chk("rst1_req", 32'(imem_req), 32'd1); chk("rst1_addr", imem_addr, 32'd0);
        chk("rst1_vld", 32'(if_valid), 32'd0); adv();
        cyc(1);
        eval_cycle(); chk("rst_ir1", if_ir, 32'h1000); chk("rst_npc1", if_npc, 32'd1); adv();
        // PC wrap across 32'hFFFFFFFF.
        br = 1'b1; tgt = 32'hFFFF_FFFE; cyc(1);
        br = 1'b0;
        eval_cycle(); chk("wrap_a0", imem_addr, 32'hFFFF_FFFE); adv();
        eval_cycle(); chk("wrap_a1", imem_addr, 32'hFFFF_FFFF); adv();
        eval_cycle(); chk("wrap_a2", imem_addr, 32'h0); chk("wrap_n0", if_npc, 32'hFFFF_FFFF);
        chk("wrap_i0", if_ir, 32'h0000_0FFE); adv();
        eval_cycle(); chk("wrap_n1", if_npc, 32'h0); chk("wrap_i1", if_ir, 32'h0000_0FFF); adv();
        eval_cycle(); chk("wrap_n2", if_npc, 32'h1); chk("wrap_i2", if_ir, 32'h0000_1000); adv();
        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rn  = ($urandom_range(0, 39) == 0);
            br  = ($urandom_range(0, 11) == 0);
            idr = ($urandom_range(0, 2) != 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            cyc(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
